// File: rtl/check_query_arbiter.sv
// check_query_arbiter
//   Shares one check engine between two requesters (0: move validator,
//   1: search/AI). A round-robin pointer picks the winner, the winner's board
//   snapshot is latched into the engine operand registers, the engine
//   handshake is driven, completion is awaited with a timeout, and the
//   16-bit attacker mask is returned to the granted requester.
//
// Ports
//   clk, RST                     clock (rising edge), async active-high reset
//   req[1:0], req_player[1:0]    per-requester level request / side to test
//   req_loc_w/b[191:0]           {req1,req0} location vectors, 96 bits each
//   req_alive_w/b[31:0]          {req1,req0} alive vectors, 16 bits each
//   gnt[1:0]                     one-hot grant, latch through RESPOND
//   rsp_valid[1:0], rsp_ack[1:0] one-hot response valid / requester accept
//   rsp_check[15:0], rsp_timeout attacker mask (0 on timeout), timeout flag
//   eng_en, eng_player           engine enable, latched player
//   eng_loc_w/b, eng_alive_w/b   latched board operands
//   eng_done, eng_is_check       engine completion pulse and result

module check_query_arbiter #(
    parameter int TIMEOUT_CYC = 64,
    parameter int CNT_W       = 7
) (
    input  logic         clk,
    input  logic         RST,
    input  logic [1:0]   req,
    input  logic [1:0]   req_player,
    input  logic [191:0] req_loc_w,
    input  logic [191:0] req_loc_b,
    input  logic [31:0]  req_alive_w,
    input  logic [31:0]  req_alive_b,
    output logic [1:0]   gnt,
    output logic [1:0]   rsp_valid,
    input  logic [1:0]   rsp_ack,
    output logic [15:0]  rsp_check,
    output logic         rsp_timeout,
    output logic         eng_en,
    output logic         eng_player,
    output logic [95:0]  eng_loc_w,
    output logic [95:0]  eng_loc_b,
    output logic [15:0]  eng_alive_w,
    output logic [15:0]  eng_alive_b,
    input  logic         eng_done,
    input  logic [15:0]  eng_is_check
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        LAUNCH    = 2'd1,
        WAIT_DONE = 2'd2,
        RESPOND   = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_t            state_r;
    state_t            state_nx;
    logic              rr_ptr_r;
    logic              winner_r;
    logic [CNT_W-1:0]  cnt_r;
    logic [1:0]        gnt_r;
    logic [1:0]        rsp_valid_r;
    logic [15:0]       rsp_check_r;
    logic              rsp_timeout_r;
    logic              eng_en_r;
    logic              eng_player_r;
    logic [95:0]       eng_loc_w_r;
    logic [95:0]       eng_loc_b_r;
    logic [15:0]       eng_alive_w_r;
    logic [15:0]       eng_alive_b_r;

    logic              win_s;
    logic              grant_s;
    logic              done_s;
    logic              tmo_s;
    logic              ack_s;
    logic              eng_en_nx_s;

    function automatic logic [1:0] onehot2(input logic idx);
        return idx ? 2'b10 : 2'b01;
    endfunction

    // Next-state decode and per-state control strobes
    always_comb begin
        state_nx = state_r;
        grant_s  = 1'b0;
        done_s   = 1'b0;
        tmo_s    = 1'b0;
        ack_s    = 1'b0;
        // Round-robin: pointer index wins if it is requesting, else the other one
        win_s    = req[rr_ptr_r] ? rr_ptr_r : ~rr_ptr_r;
        case (state_r)
            IDLE: begin
                if (req != 2'b00) begin
                    grant_s  = 1'b1;
                    state_nx = LAUNCH;
                end else begin
                    state_nx = IDLE;
                end
            end
            LAUNCH: begin
                state_nx = WAIT_DONE;
            end
            WAIT_DONE: begin
                // Done takes priority over the terminal count on the same cycle
                if (eng_done) begin
                    done_s   = 1'b1;
                    state_nx = RESPOND;
                end else if (cnt_r == CNT_LAST) begin
                    tmo_s    = 1'b1;
                    state_nx = RESPOND;
                end else begin
                    state_nx = WAIT_DONE;
                end
            end
            RESPOND: begin
                // Only the granted index may acknowledge
                if (rsp_ack[winner_r]) begin
                    ack_s    = 1'b1;
                    state_nx = IDLE;
                end else begin
                    state_nx = RESPOND;
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
        // Registering from next state keeps eng_en aligned with LAUNCH/WAIT_DONE
        eng_en_nx_s = (state_nx == LAUNCH) || (state_nx == WAIT_DONE);
    end

    // State register
    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nx;
        end
    end

    // Datapath: operand latches, grant/response registers, timeout counter
    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            rr_ptr_r      <= 1'b0;
            winner_r      <= 1'b0;
            cnt_r         <= '0;
            gnt_r         <= 2'b00;
            rsp_valid_r   <= 2'b00;
            rsp_check_r   <= 16'h0000;
            rsp_timeout_r <= 1'b0;
            eng_en_r      <= 1'b0;
            eng_player_r  <= 1'b0;
            eng_loc_w_r   <= 96'h0;
            eng_loc_b_r   <= 96'h0;
            eng_alive_w_r <= 16'h0000;
            eng_alive_b_r <= 16'h0000;
        end else begin
            eng_en_r <= eng_en_nx_s;
            case (state_r)
                IDLE: begin
                    if (grant_s) begin
                        winner_r      <= win_s;
                        gnt_r         <= onehot2(win_s);
                        eng_player_r  <= req_player[win_s];
                        eng_loc_w_r   <= win_s ? req_loc_w[191:96]  : req_loc_w[95:0];
                        eng_loc_b_r   <= win_s ? req_loc_b[191:96]  : req_loc_b[95:0];
                        eng_alive_w_r <= win_s ? req_alive_w[31:16] : req_alive_w[15:0];
                        eng_alive_b_r <= win_s ? req_alive_b[31:16] : req_alive_b[15:0];
                    end else begin
                        gnt_r <= gnt_r;
                    end
                end
                LAUNCH: begin
                    cnt_r <= '0;
                end
                WAIT_DONE: begin
                    // Saturating so the count can never wrap inside one query
                    if (cnt_r != CNT_LAST) begin
                        cnt_r <= cnt_r + CNT_ONE;
                    end else begin
                        cnt_r <= cnt_r;
                    end
                    if (done_s) begin
                        rsp_check_r   <= eng_is_check;
                        rsp_timeout_r <= 1'b0;
                        rsp_valid_r   <= onehot2(winner_r);
                    end else if (tmo_s) begin
                        rsp_check_r   <= 16'h0000;
                        rsp_timeout_r <= 1'b1;
                        rsp_valid_r   <= onehot2(winner_r);
                    end else begin
                        rsp_valid_r   <= rsp_valid_r;
                    end
                end
                RESPOND: begin
                    if (ack_s) begin
                        rsp_valid_r <= 2'b00;
                        gnt_r       <= 2'b00;
                        rr_ptr_r    <= ~winner_r;
                    end else begin
                        rsp_valid_r <= rsp_valid_r;
                    end
                end
                default: begin
                    gnt_r <= gnt_r;
                end
            endcase
        end
    end

    assign gnt         = gnt_r;
    assign rsp_valid   = rsp_valid_r;
    assign rsp_check   = rsp_check_r;
    assign rsp_timeout = rsp_timeout_r;
    assign eng_en      = eng_en_r;
    assign eng_player  = eng_player_r;
    assign eng_loc_w   = eng_loc_w_r;
    assign eng_loc_b   = eng_loc_b_r;
    assign eng_alive_w = eng_alive_w_r;
    assign eng_alive_b = eng_alive_b_r;

endmodule

// File: tb/tb_check_query_arbiter.sv
// tb_check_query_arbiter
//   Directed bench for check_query_arbiter. Expected responses are pushed to
//   a scoreboard queue when each query is launched and popped when the DUT
//   raises rsp_valid.

module tb_check_query_arbiter;

    localparam int TO = 64;

    logic         clk;
    logic         RST;
    logic [1:0]   req;
    logic [1:0]   req_player;
    logic [191:0] req_loc_w;
    logic [191:0] req_loc_b;
    logic [31:0]  req_alive_w;
    logic [31:0]  req_alive_b;
    logic [1:0]   gnt;
    logic [1:0]   rsp_valid;
    logic [1:0]   rsp_ack;
    logic [15:0]  rsp_check;
    logic         rsp_timeout;
    logic         eng_en;
    logic         eng_player;
    logic [95:0]  eng_loc_w;
    logic [95:0]  eng_loc_b;
    logic [15:0]  eng_alive_w;
    logic [15:0]  eng_alive_b;
    logic         eng_done;
    logic [15:0]  eng_is_check;

    typedef struct {
        int          idx;
        logic [15:0] val;
        logic        tmo;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    logic [95:0] locw_tab  [2];
    logic [95:0] locb_tab  [2];
    logic [15:0] alivew_tab[2];
    logic        player_tab[2];

    check_query_arbiter #(.TIMEOUT_CYC(TO), .CNT_W(7)) dut (
        .clk(clk), .RST(RST), .req(req), .req_player(req_player),
        .req_loc_w(req_loc_w), .req_loc_b(req_loc_b),
        .req_alive_w(req_alive_w), .req_alive_b(req_alive_b),
        .gnt(gnt), .rsp_valid(rsp_valid), .rsp_ack(rsp_ack),
        .rsp_check(rsp_check), .rsp_timeout(rsp_timeout),
        .eng_en(eng_en), .eng_player(eng_player),
        .eng_loc_w(eng_loc_w), .eng_loc_b(eng_loc_b),
        .eng_alive_w(eng_alive_w), .eng_alive_b(eng_alive_b),
        .eng_done(eng_done), .eng_is_check(eng_is_check)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Runs one query from IDLE (req already driven) up to rsp_valid.
    // done_at: WAIT_DONE cycle index on which eng_done pulses (<0: never).
    task automatic run_query(input int idx, input int done_at, input logic [15:0] val,
                             input logic drop_req);
        int   cyc;
        int   exp_cyc;
        exp_t e;
        exp_t got;
        step();
        chk("gnt_launch", {126'd0, gnt}, {126'd0, (idx == 1) ? 2'b10 : 2'b01});
        chk("eng_en_launch", {127'd0, eng_en}, 128'd1);
        chk("eng_player", {127'd0, eng_player}, {127'd0, player_tab[idx]});
        chk("eng_loc_w", {32'd0, eng_loc_w}, {32'd0, locw_tab[idx]});
        chk("eng_loc_b", {32'd0, eng_loc_b}, {32'd0, locb_tab[idx]});
        chk("eng_alive_w", {112'd0, eng_alive_w}, {112'd0, alivew_tab[idx]});
        e.idx = idx;
        if (done_at >= 0 && done_at < TO) begin
            e.val = val;
            e.tmo = 1'b0;
            exp_cyc = done_at + 1;
        end else begin
            e.val = 16'h0000;
            e.tmo = 1'b1;
            exp_cyc = TO;
        end
        sb.push_back(e);
        if (drop_req) req = 2'b00;
        step();
        cyc = 0;
        while (rsp_valid == 2'b00 && cyc < TO + 8) begin
            if (cyc == done_at) begin
                eng_done     = 1'b1;
                eng_is_check = val;
            end
            step();
            eng_done     = 1'b0;
            eng_is_check = 16'hdead;
            cyc++;
        end
        chk("wait_cycles", 128'(cyc), 128'(exp_cyc));
        chk("eng_en_respond", {127'd0, eng_en}, 128'd0);
        if (sb.size() == 0) begin
            chk("sb_empty", 128'd1, 128'd0);
        end else begin
            got = sb.pop_front();
            chk("rsp_valid", {126'd0, rsp_valid}, {126'd0, (got.idx == 1) ? 2'b10 : 2'b01});
            chk("rsp_check", {112'd0, rsp_check}, {112'd0, got.val});
            chk("rsp_timeout", {127'd0, rsp_timeout}, {127'd0, got.tmo});
        end
    endtask

    // Holds the response for 'hold' cycles (checking stability), then acks it
    task automatic ack_rsp(input int idx, input int hold);
        logic [1:0]  v0;
        logic [15:0] c0;
        v0 = rsp_valid;
        c0 = rsp_check;
        for (int i = 0; i < hold; i++) begin
            step();
            chk("rsp_hold_valid", {126'd0, rsp_valid}, {126'd0, v0});
            chk("rsp_hold_check", {112'd0, rsp_check}, {112'd0, c0});
        end
        rsp_ack[idx] = 1'b1;
        step();
        rsp_ack = 2'b00;
        chk("ack_valid_clr", {126'd0, rsp_valid}, 128'd0);
        chk("ack_gnt_clr", {126'd0, gnt}, 128'd0);
        chk("ack_eng_en_low", {127'd0, eng_en}, 128'd0);
    endtask

    initial begin
        locw_tab[0]   = 96'h0123456789abcdef01234567;
        locw_tab[1]   = 96'hfedcba9876543210fedcba98;
        locb_tab[0]   = 96'h111122223333444455556666;
        locb_tab[1]   = 96'h777788889999aaaabbbbcccc;
        alivew_tab[0] = 16'h00ff;
        alivew_tab[1] = 16'hf0f0;
        player_tab[0] = 1'b1;
        player_tab[1] = 1'b0;

        RST          = 1'b1;
        req          = 2'b00;
        req_player   = {player_tab[1], player_tab[0]};
        req_loc_w    = {locw_tab[1], locw_tab[0]};
        req_loc_b    = {locb_tab[1], locb_tab[0]};
        req_alive_w  = {alivew_tab[1], alivew_tab[0]};
        req_alive_b  = {16'h1234, 16'h5678};
        rsp_ack      = 2'b00;
        eng_done     = 1'b0;
        eng_is_check = 16'h0000;

        repeat (2) @(posedge clk);
        @(negedge clk);
        RST = 1'b0;
        chk("rst_gnt", {126'd0, gnt}, 128'd0);
        chk("rst_valid", {126'd0, rsp_valid}, 128'd0);
        chk("rst_check", {112'd0, rsp_check}, 128'd0);
        chk("rst_timeout", {127'd0, rsp_timeout}, 128'd0);
        chk("rst_eng_en", {127'd0, eng_en}, 128'd0);
        chk("rst_loc_w", {32'd0, eng_loc_w}, 128'd0);

        // Reset in the middle of WAIT_DONE
        req = 2'b10;
        step();
        chk("t1_gnt", {126'd0, gnt}, 128'd2);
        step();
        step();
        chk("t1_eng_en", {127'd0, eng_en}, 128'd1);
        #2 RST = 1'b1;
        #1;
        chk("t1_rst_eng_en", {127'd0, eng_en}, 128'd0);
        chk("t1_rst_gnt", {126'd0, gnt}, 128'd0);
        chk("t1_rst_valid", {126'd0, rsp_valid}, 128'd0);
        @(negedge clk);
        RST = 1'b0;
        req = 2'b11;
        run_query(0, 5, 16'h1234, 1'b1);
        ack_rsp(0, 1);

        // Single requester, done after 3 cycles, response held until ack
        req = 2'b01;
        run_query(0, 2, 16'h0080, 1'b1);
        ack_rsp(0, 3);

        // Both requesting continuously: grants alternate 1,0,1,0
        req = 2'b11;
        run_query(1, 0, 16'h4001, 1'b0);
        ack_rsp(1, 0);
        run_query(0, 4, 16'h0c00, 1'b0);
        ack_rsp(0, 0);
        run_query(1, 1, 16'h8000, 1'b0);
        ack_rsp(1, 0);
        run_query(0, 7, 16'h0011, 1'b1);

        // Stray ack on the non-granted index and stray done while responding
        rsp_ack = 2'b10;
        eng_done = 1'b1;
        eng_is_check = 16'hbeef;
        step();
        rsp_ack = 2'b00;
        eng_done = 1'b0;
        chk("t6_stray_ack_valid", {126'd0, rsp_valid}, 128'd1);
        chk("t6_stray_ack_check", {112'd0, rsp_check}, 128'h0011);
        chk("t6_stray_ack_gnt", {126'd0, gnt}, 128'd1);
        ack_rsp(0, 0);

        // Timeout: no eng_done at all
        req = 2'b01;
        run_query(0, -1, 16'h0000, 1'b1);
        ack_rsp(0, 2);

        // Done on the terminal-count cycle wins over timeout
        req = 2'b10;
        run_query(1, TO - 1, 16'h0002, 1'b1);
        ack_rsp(1, 0);

        // Stray eng_done in IDLE is ignored
        eng_done = 1'b1;
        eng_is_check = 16'hffff;
        step();
        step();
        eng_done = 1'b0;
        chk("t6_idle_gnt", {126'd0, gnt}, 128'd0);
        chk("t6_idle_eng_en", {127'd0, eng_en}, 128'd0);
        chk("t6_idle_valid", {126'd0, rsp_valid}, 128'd0);
        chk("t6_idle_check", {112'd0, rsp_check}, 128'h0002);

        // Pointer now favours 0 after the index-1 query
        req = 2'b11;
        run_query(0, 3, 16'h0a0a, 1'b1);
        ack_rsp(0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
